// File: rtl/bin2bcd_serial.sv
// Serial binary-to-BCD converter using the shift-and-add-3 (double-dabble) method.
// One operand bit per clock, MSB first. The result and overflow flag are held until the next conversion completes.
module bin2bcd_serial #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  overflow
);

    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam int BCD_W = 4 * DIGITS;

    typedef enum logic {
        IDLE,
        SHIFT
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BIN_W-1:0]   operand_q, operand_d;
    logic [BCD_W-1:0]   scratch_q, scratch_d;
    logic               ovfScratch_q, ovfScratch_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic               ovf_q, ovf_d;
    logic               done_q, done_d;

    logic [BCD_W-1:0]   adjusted;
    logic [BCD_W-1:0]   shifted;
    logic               carryOut;
    logic               lastShift;

    assign lastShift = (cnt_q == CNT_W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = SHIFT;
            SHIFT:   if (lastShift) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy     = (state_q == SHIFT);
        done     = done_q;
        bcd      = bcd_q;
        overflow = ovf_q;
    end

    // Any digit of 5 or more would become >= 10 after doubling, so +3 pushes its carry into the next digit.
    always_comb begin
        adjusted = scratch_q;
        for (int d = 0; d < DIGITS; d++) begin
            if (scratch_q[4*d +: 4] >= 4'd5) begin
                adjusted[4*d +: 4] = scratch_q[4*d +: 4] + 4'd3;
            end
        end
    end

    // A bit leaving the top digit means the value has reached 10^DIGITS; the remaining digits stay value mod 10^DIGITS.
    always_comb begin
        shifted  = {adjusted[BCD_W-2:0], operand_q[BIN_W-1]};
        carryOut = adjusted[BCD_W-1];
    end

    always_comb begin
        cnt_d        = cnt_q;
        operand_d    = operand_q;
        scratch_d    = scratch_q;
        ovfScratch_d = ovfScratch_q;
        bcd_d        = bcd_q;
        ovf_d        = ovf_q;
        done_d       = 1'b0;
        if (state_q == IDLE) begin
            if (start) begin
                operand_d    = bin;
                scratch_d    = '0;
                ovfScratch_d = 1'b0;
                cnt_d        = CNT_W'(BIN_W);
            end
        end else begin
            operand_d    = operand_q << 1;
            scratch_d    = shifted;
            ovfScratch_d = ovfScratch_q | carryOut;
            cnt_d        = cnt_q - CNT_W'(1);
            if (lastShift) begin
                bcd_d  = shifted;
                ovf_d  = ovfScratch_q | carryOut;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q        <= '0;
            operand_q    <= '0;
            scratch_q    <= '0;
            ovfScratch_q <= 1'b0;
            bcd_q        <= '0;
            ovf_q        <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            operand_q    <= operand_d;
            scratch_q    <= scratch_d;
            ovfScratch_q <= ovfScratch_d;
            bcd_q        <= bcd_d;
            ovf_q        <= ovf_d;
            done_q       <= done_d;
        end
    end

endmodule

// File: tb/tb_bin2bcd_serial.sv
// Bench for bin2bcd_serial: three instances (8/3, 8/2, 16/5) checked against a decimal reference model.
// Expected results are queued when a start is driven and compared when done appears.
module tb_bin2bcd_serial;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        startA, busyA, doneA, ovfA;
    logic [7:0]  binA;
    logic [11:0] bcdA;
    logic        startB, busyB, doneB, ovfB;
    logic [7:0]  binB;
    logic [7:0]  bcdB;
    logic        startC, busyC, doneC, ovfC;
    logic [15:0] binC;
    logic [19:0] bcdC;

    bin2bcd_serial #(.BIN_W(8), .DIGITS(3)) dutA (
        .clk(clk), .rst(rst), .start(startA), .bin(binA),
        .busy(busyA), .done(doneA), .bcd(bcdA), .overflow(ovfA));
    bin2bcd_serial #(.BIN_W(8), .DIGITS(2)) dutB (
        .clk(clk), .rst(rst), .start(startB), .bin(binB),
        .busy(busyB), .done(doneB), .bcd(bcdB), .overflow(ovfB));
    bin2bcd_serial #(.BIN_W(16), .DIGITS(5)) dutC (
        .clk(clk), .rst(rst), .start(startC), .bin(binC),
        .busy(busyC), .done(doneC), .bcd(bcdC), .overflow(ovfC));

    typedef struct {
        logic [39:0] bcd;
        logic        ovf;
        int          val;
    } exp_t;

    exp_t qA[$];
    exp_t qB[$];
    exp_t qC[$];
    int compared   = 0;
    int mismatched = 0;

    // Decimal reference: low digits of the value, overflow when anything is left above them.
    function automatic exp_t refModel(input int unsigned v, input int digits);
        exp_t        e;
        int unsigned r;
        r     = v;
        e.bcd = '0;
        e.val = int'(v);
        for (int d = 0; d < digits; d++) begin
            e.bcd[4*d +: 4] = 4'(r % 10);
            r = r / 10;
        end
        e.ovf = (r != 0);
        return e;
    endfunction

    function automatic logic [39:0] obsBcd(input int which);
        case (which)
            0:       return {28'd0, bcdA};
            1:       return {32'd0, bcdB};
            default: return {20'd0, bcdC};
        endcase
    endfunction

    function automatic logic obsOvf(input int which);
        case (which)
            0:       return ovfA;
            1:       return ovfB;
            default: return ovfC;
        endcase
    endfunction

    function automatic logic obsBusy(input int which);
        case (which)
            0:       return busyA;
            1:       return busyB;
            default: return busyC;
        endcase
    endfunction

    // Drives a one-cycle start and queues its expected result; returns 1 ns after the accepting edge.
    task automatic applyStimulus(input int which, input int unsigned v);
        case (which)
            0: begin startA = 1'b1; binA = 8'(v);  qA.push_back(refModel(v, 3)); end
            1: begin startB = 1'b1; binB = 8'(v);  qB.push_back(refModel(v, 2)); end
            default: begin startC = 1'b1; binC = 16'(v); qC.push_back(refModel(v, 5)); end
        endcase
        @(posedge clk);
        #1;
        startA = 1'b0;
        startB = 1'b0;
        startC = 1'b0;
    endtask

    // Counts edges until done is seen; cycles = -1 when the bound expires.
    task automatic waitDone(input int which, input int limit, output int cycles);
        cycles = -1;
        for (int k = 1; k <= limit; k++) begin
            @(posedge clk);
            #1;
            if ((which == 0 && doneA) || (which == 1 && doneB) || (which == 2 && doneC)) begin
                cycles = k;
                break;
            end
        end
    endtask

    task automatic popExp(input int which, output exp_t e, output bit ok);
        ok    = 1'b1;
        e.bcd = '1;
        e.ovf = 1'b1;
        e.val = -1;
        case (which)
            0:       if (qA.size() > 0) e = qA.pop_front(); else ok = 1'b0;
            1:       if (qB.size() > 0) e = qB.pop_front(); else ok = 1'b0;
            default: if (qC.size() > 0) e = qC.pop_front(); else ok = 1'b0;
        endcase
    endtask

    task automatic test_reset();
        compared++; if (busyA !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_busyA actual=%b required=0", busyA); end
        compared++; if (doneA !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_doneA actual=%b required=0", doneA); end
        compared++; if (bcdA !== 12'h000) begin mismatched++; $display("[TB] FAIL reset_bcdA actual=%h required=000", bcdA); end
        compared++; if (ovfA !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_ovfA actual=%b required=0", ovfA); end
        compared++; if (bcdB !== 8'h00 || ovfB !== 1'b0 || busyB !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_B actual=%h/%b/%b required=00/0/0", bcdB, ovfB, busyB); end
        compared++; if (bcdC !== 20'h0 || ovfC !== 1'b0 || busyC !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_C actual=%h/%b/%b required=0/0/0", bcdC, ovfC, busyC); end
    endtask

    // Fixed operands through the default instance, including latency and result hold during conversion.
    task automatic test_basic();
        int          vals[4] = '{255, 0, 99, 100};
        logic [11:0] lastBcd;
        int          cyc;
        exp_t        e;
        bit          ok;
        lastBcd = 12'h000;
        foreach (vals[i]) begin
            applyStimulus(0, vals[i]);
            compared++; if (busyA !== 1'b1) begin mismatched++; $display("[TB] FAIL basic_busy v=%0d actual=%b required=1", vals[i], busyA); end
            compared++; if (bcdA !== lastBcd) begin mismatched++; $display("[TB] FAIL basic_hold v=%0d actual=%h required=%h", vals[i], bcdA, lastBcd); end
            waitDone(0, 20, cyc);
            popExp(0, e, ok);
            compared++; if (cyc !== 8) begin mismatched++; $display("[TB] FAIL basic_latency v=%0d actual=%0d required=8", vals[i], cyc); end
            compared++; if (!ok || bcdA !== e.bcd[11:0]) begin mismatched++; $display("[TB] FAIL basic_bcd v=%0d actual=%h required=%h", vals[i], bcdA, e.bcd[11:0]); end
            compared++; if (ovfA !== e.ovf) begin mismatched++; $display("[TB] FAIL basic_ovf v=%0d actual=%b required=%b", vals[i], ovfA, e.ovf); end
            compared++; if (busyA !== 1'b0) begin mismatched++; $display("[TB] FAIL basic_busy_at_done v=%0d actual=%b required=0", vals[i], busyA); end
            lastBcd = e.bcd[11:0];
        end
    endtask

    task automatic test_overflow();
        int   vals[2] = '{200, 99};
        int   cyc;
        exp_t e;
        bit   ok;
        foreach (vals[i]) begin
            applyStimulus(1, vals[i]);
            waitDone(1, 20, cyc);
            popExp(1, e, ok);
            compared++; if (cyc !== 8) begin mismatched++; $display("[TB] FAIL ovf_latency v=%0d actual=%0d required=8", vals[i], cyc); end
            compared++; if (!ok || bcdB !== e.bcd[7:0]) begin mismatched++; $display("[TB] FAIL ovf_bcd v=%0d actual=%h required=%h", vals[i], bcdB, e.bcd[7:0]); end
            compared++; if (ovfB !== e.ovf) begin mismatched++; $display("[TB] FAIL ovf_flag v=%0d actual=%b required=%b", vals[i], ovfB, e.ovf); end
        end
    endtask

    // A start during busy is dropped; a start held through the done cycle launches the next conversion.
    task automatic test_back_to_back();
        int   cyc;
        exp_t e;
        bit   ok;
        applyStimulus(0, 37);
        repeat (2) @(posedge clk);
        #1;
        startA = 1'b1;
        binA   = 8'd200;
        @(posedge clk);
        #1;
        startA = 1'b0;
        binA   = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        compared++; if (doneA !== 1'b0 || busyA !== 1'b1) begin mismatched++; $display("[TB] FAIL b2b_early actual=done%b/busy%b required=done0/busy1", doneA, busyA); end
        startA = 1'b1;
        binA   = 8'd200;
        qA.push_back(refModel(200, 3));
        waitDone(0, 6, cyc);
        popExp(0, e, ok);
        compared++; if (cyc !== 2) begin mismatched++; $display("[TB] FAIL b2b_first_latency actual=%0d required=2", cyc); end
        compared++; if (!ok || bcdA !== e.bcd[11:0]) begin mismatched++; $display("[TB] FAIL b2b_first_bcd actual=%h required=%h", bcdA, e.bcd[11:0]); end
        @(posedge clk);
        #1;
        startA = 1'b0;
        binA   = 8'd0;
        compared++; if (busyA !== 1'b1 || doneA !== 1'b0) begin mismatched++; $display("[TB] FAIL b2b_restart actual=busy%b/done%b required=busy1/done0", busyA, doneA); end
        compared++; if (bcdA !== 12'h037) begin mismatched++; $display("[TB] FAIL b2b_hold actual=%h required=037", bcdA); end
        waitDone(0, 20, cyc);
        popExp(0, e, ok);
        compared++; if (cyc !== 8) begin mismatched++; $display("[TB] FAIL b2b_second_latency actual=%0d required=8", cyc); end
        compared++; if (!ok || bcdA !== e.bcd[11:0]) begin mismatched++; $display("[TB] FAIL b2b_second_bcd actual=%h required=%h", bcdA, e.bcd[11:0]); end
    endtask

    task automatic test_reset_abort();
        int   cyc;
        exp_t e;
        bit   ok;
        applyStimulus(0, 128);
        repeat (4) @(posedge clk);
        #2;
        rst    = 1'b1;
        startA = 1'b1;
        binA   = 8'd55;
        #1;
        compared++; if (busyA !== 1'b0 || doneA !== 1'b0) begin mismatched++; $display("[TB] FAIL abort_async actual=busy%b/done%b required=0/0", busyA, doneA); end
        compared++; if (bcdA !== 12'h000 || ovfA !== 1'b0) begin mismatched++; $display("[TB] FAIL abort_clear actual=%h/%b required=000/0", bcdA, ovfA); end
        qA.delete();
        repeat (2) @(posedge clk);
        #1;
        rst    = 1'b0;
        startA = 1'b0;
        binA   = 8'd0;
        waitDone(0, 12, cyc);
        compared++; if (cyc !== -1) begin mismatched++; $display("[TB] FAIL abort_no_done actual=%0d required=-1", cyc); end
        compared++; if (busyA !== 1'b0 || bcdA !== 12'h000) begin mismatched++; $display("[TB] FAIL abort_idle actual=busy%b/%h required=0/000", busyA, bcdA); end
        applyStimulus(0, 128);
        waitDone(0, 20, cyc);
        popExp(0, e, ok);
        compared++; if (cyc !== 8) begin mismatched++; $display("[TB] FAIL abort_restart_latency actual=%0d required=8", cyc); end
        compared++; if (!ok || bcdA !== e.bcd[11:0]) begin mismatched++; $display("[TB] FAIL abort_restart_bcd actual=%h required=%h", bcdA, e.bcd[11:0]); end
    endtask

    task automatic test_wide();
        int   cyc;
        exp_t e;
        bit   ok;
        applyStimulus(2, 65535);
        waitDone(2, 30, cyc);
        popExp(2, e, ok);
        compared++; if (cyc !== 16) begin mismatched++; $display("[TB] FAIL wide_latency actual=%0d required=16", cyc); end
        compared++; if (!ok || bcdC !== e.bcd[19:0]) begin mismatched++; $display("[TB] FAIL wide_bcd actual=%h required=%h", bcdC, e.bcd[19:0]); end
        compared++; if (ovfC !== 1'b0) begin mismatched++; $display("[TB] FAIL wide_ovf actual=%b required=0", ovfC); end
    endtask

    task automatic test_random();
        int          cyc;
        int unsigned v;
        exp_t        e;
        bit          ok;
        for (int which = 0; which < 3; which++) begin
            for (int n = 0; n < 8; n++) begin
                v = (which == 2) ? $urandom_range(65535, 0) : $urandom_range(255, 0);
                applyStimulus(which, v);
                waitDone(which, 30, cyc);
                popExp(which, e, ok);
                compared++; if (cyc !== ((which == 2) ? 16 : 8)) begin mismatched++; $display("[TB] FAIL rand_latency dut=%0d v=%0d actual=%0d", which, v, cyc); end
                compared++; if (!ok || obsBcd(which) !== e.bcd) begin mismatched++; $display("[TB] FAIL rand_bcd dut=%0d v=%0d actual=%h required=%h", which, v, obsBcd(which), e.bcd); end
                compared++; if (obsOvf(which) !== e.ovf || obsBusy(which) !== 1'b0) begin mismatched++; $display("[TB] FAIL rand_ovf dut=%0d v=%0d actual=%b required=%b", which, v, obsOvf(which), e.ovf); end
            end
        end
    endtask

    initial begin
        rst    = 1'b1;
        startA = 1'b0; binA = '0;
        startB = 1'b0; binB = '0;
        startC = 1'b0; binC = '0;
        #12;
        test_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        test_basic();
        test_overflow();
        test_back_to_back();
        test_reset_abort();
        test_wide();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
